ram_bitfield: RTL and testbench

Parametrised successor to the single-bit 2R1W data RAM. It holds 2**AWIDTH words of DWIDTH bits and provides two registered read ports, each returning both the addressed word and one selected bit. A single write port supports word writes and single-cycle bit read-modify-write operations. After every reset a built-in clear sequencer zeroes the array, so the CPU core never reads uninitialised flags.

---
 rtl/ram_bitfield.sv | 156 +++++++++++++++
 tb/tb_ram_bitfield.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bitfield.sv
// ram_bitfield: 2R1W word/bit RAM with bit read-modify-write ops and a
// self-clearing sequencer that zeroes the whole array after every reset.
module ram_bitfield #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8,
  parameter int BWIDTH = $clog2(DWIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  input  logic [AWIDTH-1:0] port_a_address,
  input  logic [BWIDTH-1:0] port_a_bitsel,
  output logic [DWIDTH-1:0] port_a_out,
  output logic              port_a_bit,
  input  logic [AWIDTH-1:0] port_b_address,
  input  logic [BWIDTH-1:0] port_b_bitsel,
  output logic [DWIDTH-1:0] port_b_out,
  output logic              port_b_bit,
  input  logic [AWIDTH-1:0] port_c_address,
  input  logic [BWIDTH-1:0] port_c_bitsel,
  input  logic [DWIDTH-1:0] port_c_data,
  input  logic [1:0]        port_c_op,
  input  logic              port_c_we
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

  localparam logic [1:0] OP_WORD    = 2'b00;
  localparam logic [1:0] OP_BITWR   = 2'b01;
  localparam logic [1:0] OP_BITTGL  = 2'b10;
  localparam logic [1:0] OP_WORDXOR = 2'b11;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t state_q, state_d;
  logic [AWIDTH-1:0] clear_count;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [DWIDTH-1:0] c_old;
  logic [DWIDTH-1:0] c_new;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] a_word;
  logic [DWIDTH-1:0] b_word;

  // State register: reset always restarts the clear sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // Leave CLEAR on the edge that zeroes the top address; READY is terminal.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      CLEAR: begin
        busy = 1'b1;
        if (clear_count == LAST_ADDR) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Clear address counter; parks at the top address instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_count <= '0;
    end else if (state_q == CLEAR && clear_count != LAST_ADDR) begin
      clear_count <= clear_count + AWIDTH'(1);
    end
  end

  // Post-write word for port C, built from the pre-edge contents.
  always_comb begin
    c_old = mem[port_c_address];
    c_new = c_old;
    case (port_c_op)
      OP_WORD:    c_new = port_c_data;
      OP_BITWR:   c_new[port_c_bitsel] = port_c_data[0];
      OP_BITTGL:  c_new[port_c_bitsel] = ~c_old[port_c_bitsel];
      OP_WORDXOR: c_new = c_old ^ port_c_data;
      default:    c_new = c_old;
    endcase
  end

  // Single array write port, owned by the sequencer during CLEAR so core writes are dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clear_count;
    mem_wdata = '0;
    if (state_q == CLEAR) begin
      mem_we = 1'b1;
    end else if (port_c_we) begin
      mem_we    = 1'b1;
      mem_waddr = port_c_address;
      mem_wdata = c_new;
    end
  end

  // Array storage; contents are never reset directly, only swept by the sequencer.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Write-first bypass: a read hitting the address being written sees the new word.
  always_comb begin
    a_word = mem[port_a_address];
    b_word = mem[port_b_address];
    if (port_c_we && port_a_address == port_c_address) begin
      a_word = c_new;
    end
    if (port_c_we && port_b_address == port_c_address) begin
      b_word = c_new;
    end
  end

  // Registered read ports, held at zero until the clear sequence finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_a_out <= '0;
      port_a_bit <= 1'b0;
      port_b_out <= '0;
      port_b_bit <= 1'b0;
    end else if (state_q == READY) begin
      port_a_out <= a_word;
      port_a_bit <= a_word[port_a_bitsel];
      port_b_out <= b_word;
      port_b_bit <= b_word[port_b_bitsel];
    end else begin
      port_a_out <= '0;
      port_a_bit <= 1'b0;
      port_b_out <= '0;
      port_b_bit <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_bitfield.sv
// tb_ram_bitfield: scoreboard bench for ram_bitfield (AWIDTH=8, DWIDTH=8).
module tb_ram_bitfield;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int BW    = 3;
  localparam int DEPTH = 256;

  logic          clk;
  logic          rst;
  logic          busy;
  logic [AW-1:0] a_addr, b_addr, c_addr;
  logic [BW-1:0] a_bs, b_bs, c_bs;
  logic [DW-1:0] a_out, b_out, c_data;
  logic          a_bit, b_bit;
  logic [1:0]    c_op;
  logic          c_we;

  typedef struct packed {
    logic [DW-1:0] a;
    logic          ab;
    logic [DW-1:0] b;
    logic          bb;
    logic          busy;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            clear_edges;
  int            compare_count;
  int            fail_count;

  ram_bitfield #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk),
    .rst(rst),
    .busy(busy),
    .port_a_address(a_addr),
    .port_a_bitsel(a_bs),
    .port_a_out(a_out),
    .port_a_bit(a_bit),
    .port_b_address(b_addr),
    .port_b_bitsel(b_bs),
    .port_b_out(b_out),
    .port_b_bit(b_bit),
    .port_c_address(c_addr),
    .port_c_bitsel(c_bs),
    .port_c_data(c_data),
    .port_c_op(c_op),
    .port_c_we(c_we)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compare_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle, predict the result from the model, and check it after the edge.
  task automatic applyStimulus(input logic [AW-1:0] aa, input logic [BW-1:0] abs,
                               input logic [AW-1:0] ba, input logic [BW-1:0] bbs,
                               input logic [AW-1:0] ca, input logic [BW-1:0] cbs,
                               input logic [DW-1:0] cd, input logic [1:0] op, input logic we,
                               input string tag);
    exp_t          e;
    exp_t          got;
    logic [DW-1:0] cur, nw, wa, wb;
    a_addr = aa; a_bs = abs; b_addr = ba; b_bs = bbs;
    c_addr = ca; c_bs = cbs; c_data = cd; c_op = op; c_we = we;
    e = '0;
    if (clear_edges < DEPTH) begin
      model_mem[clear_edges] = '0;
      clear_edges++;
      e.busy = (clear_edges < DEPTH);
    end else begin
      cur = model_mem[ca];
      nw  = cur;
      if (we) begin
        case (op)
          2'b00: nw = cd;
          2'b01: nw[cbs] = cd[0];
          2'b10: nw[cbs] = ~cur[cbs];
          default: nw = cur ^ cd;
        endcase
      end
      wa = (we && aa == ca) ? nw : model_mem[aa];
      wb = (we && ba == ca) ? nw : model_mem[ba];
      e.a  = wa;
      e.ab = wa[abs];
      e.b  = wb;
      e.bb = wb[bbs];
      e.busy = 1'b0;
      if (we) model_mem[ca] = nw;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checkOutput({tag, "_a"}, {24'h0, a_out}, {24'h0, got.a});
    checkOutput({tag, "_abit"}, {31'h0, a_bit}, {31'h0, got.ab});
    checkOutput({tag, "_b"}, {24'h0, b_out}, {24'h0, got.b});
    checkOutput({tag, "_bbit"}, {31'h0, b_bit}, {31'h0, got.bb});
    checkOutput({tag, "_busy"}, {31'h0, busy}, {31'h0, got.busy});
  endtask

  task automatic idleCycle(input string tag);
    applyStimulus(AW'($urandom_range(255, 0)), BW'($urandom_range(7, 0)),
                  AW'($urandom_range(255, 0)), BW'($urandom_range(7, 0)),
                  '0, '0, '0, 2'b00, 1'b0, tag);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_a"}, {24'h0, a_out}, 32'h0);
    checkOutput({tag, "_abit"}, {31'h0, a_bit}, 32'h0);
    checkOutput({tag, "_b"}, {24'h0, b_out}, 32'h0);
    checkOutput({tag, "_bbit"}, {31'h0, b_bit}, 32'h0);
    checkOutput({tag, "_busy"}, {31'h0, busy}, 32'h1);
  endtask

  // Reads sweep A ascending and B descending with no writes.
  task automatic sweepReads(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(AW'(i), BW'($urandom_range(7, 0)), AW'(DEPTH - 1 - i), BW'($urandom_range(7, 0)),
                    '0, '0, '0, 2'b00, 1'b0, tag);
    end
  endtask

  // Assert reset mid-cycle, hold it across an edge with a write pending, then release.
  task automatic pulseReset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    checkResetState({tag, "_async"});
    c_we = 1'b1; c_op = 2'b00; c_addr = 8'h05; c_data = 8'h77;
    @(posedge clk);
    #1;
    checkResetState({tag, "_held"});
    rst = 1'b0;
    c_we = 1'b0;
    clear_edges = 0;
    sb.delete();
  endtask

  initial begin
    compare_count = 0;
    fail_count    = 0;
    clear_edges   = 0;
    rst    = 1'b1;
    a_addr = '0; a_bs = '0; b_addr = '0; b_bs = '0;
    c_addr = '0; c_bs = '0; c_data = '0; c_op = '0; c_we = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    #3;
    checkResetState("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] clear after reset, then sweep reads");
    for (int i = 0; i < DEPTH; i++) idleCycle("clear1");
    checkOutput("clear1_busy_done", {31'h0, busy}, 32'h0);
    sweepReads("zero_sweep");

    $display("[TB] walking word writes, then cross-port read sweep");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(AW'($urandom_range(255, 0)), BW'($urandom_range(7, 0)),
                    AW'($urandom_range(255, 0)), BW'($urandom_range(7, 0)),
                    AW'(i), BW'(0), DW'(i) ^ 8'h5A, 2'b00, 1'b1, "walk_wr");
    end
    sweepReads("walk_rd");
    applyStimulus(8'h3C, 3'd0, 8'hC3, 3'd0, '0, '0, '0, 2'b00, 1'b0, "walk_pick");
    checkOutput("walk_const_a", {24'h0, a_out}, 32'h66);
    checkOutput("walk_const_b", {24'h0, b_out}, 32'h99);

    $display("[TB] bit operations on 0x10");
    applyStimulus(8'h10, 3'd1, 8'h11, 3'd0, 8'h10, 3'd0, 8'h00, 2'b00, 1'b1, "bit_init");
    applyStimulus(8'h10, 3'd3, 8'h10, 3'd0, 8'h10, 3'd3, 8'h01, 2'b01, 1'b1, "bit_wr3");
    checkOutput("bit_wr3_const", {24'h0, a_out}, 32'h08);
    applyStimulus(8'h10, 3'd0, 8'h10, 3'd3, 8'h10, 3'd0, 8'h00, 2'b10, 1'b1, "bit_tgl0");
    checkOutput("bit_tgl0_const", {24'h0, a_out}, 32'h09);
    applyStimulus(8'h10, 3'd3, 8'h10, 3'd0, 8'h10, 3'd3, 8'h00, 2'b10, 1'b1, "bit_tgl3");
    checkOutput("bit_tgl3_const", {24'h0, a_out}, 32'h01);
    applyStimulus(8'h11, 3'd0, 8'h10, 3'd0, 8'h10, 3'd0, 8'hFF, 2'b11, 1'b1, "bit_xor");
    applyStimulus(8'h10, 3'd1, 8'h10, 3'd0, 8'h00, 3'd0, 8'h00, 2'b00, 1'b0, "bit_read");
    checkOutput("bit_final_word", {24'h0, a_out}, 32'hFE);
    checkOutput("bit_final_bit1", {31'h0, a_bit}, 32'h1);

    $display("[TB] write-first bypass on both read ports");
    applyStimulus(8'h20, 3'd0, 8'h20, 3'd0, 8'h20, 3'd0, 8'h00, 2'b00, 1'b1, "byp_zero");
    applyStimulus(8'h20, 3'd0, 8'h20, 3'd2, 8'h20, 3'd0, 8'hA5, 2'b00, 1'b1, "byp_word");
    checkOutput("byp_const_a", {24'h0, a_out}, 32'hA5);
    checkOutput("byp_const_b", {24'h0, b_out}, 32'hA5);

    $display("[TB] writes during clear are dropped");
    pulseReset("rst_ready");
    idleCycle("clr_e1");
    applyStimulus(8'h00, 3'd0, 8'h03, 3'd0, 8'h03, 3'd0, 8'hFF, 2'b00, 1'b1, "clr_e2");
    applyStimulus(8'h00, 3'd0, 8'h03, 3'd0, 8'h00, 3'd0, 8'hFF, 2'b00, 1'b1, "clr_e3");
    for (int i = 3; i < DEPTH; i++) idleCycle("clear2");
    applyStimulus(8'h03, 3'd0, 8'h00, 3'd0, 8'h00, 3'd0, 8'h00, 2'b00, 1'b0, "clr_drop");
    checkOutput("clr_drop_03", {24'h0, a_out}, 32'h00);
    checkOutput("clr_drop_00", {24'h0, b_out}, 32'h00);

    $display("[TB] reset in the middle of a write sweep");
    for (int i = 0; i < 100; i++) begin
      applyStimulus(AW'($urandom_range(255, 0)), BW'($urandom_range(7, 0)),
                    AW'(i), BW'($urandom_range(7, 0)),
                    AW'(i), BW'(0), DW'($urandom_range(255, 1)), 2'b00, 1'b1, "rw_sweep");
    end
    pulseReset("rst_mid");
    for (int i = 0; i < DEPTH; i++) idleCycle("clear3");
    sweepReads("post_rst");

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
